// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter and transfer sequencer sharing one SPI master among NUM_REQ requesters.
// Latches the winner's byte, launches one transfer, then reports done or err back to the owner.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      spi_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_start,
  input  logic                      m_busy,
  input  logic                      m_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  // Counter reads k in the k-th cycle after m_start; err lands in cycle TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_XFER,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic               r_start;
  logic [DATA_W-1:0]  r_data;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid_seen;

  logic [IDX_W-1:0]   w_win;
  logic               w_any;

  // Scan from the farthest candidate down so the first set bit after r_ptr is the last one written.
  // NOTE: every always_comb output gets a default before any conditional assignment, so no latch is inferred.
  always_comb begin
    w_win = '0;
    w_any = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_win = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_done       <= '0;
      r_err        <= 1'b0;
      r_start      <= 1'b0;
      r_data       <= '0;
      r_ptr        <= IDX_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_cnt        <= '0;
      r_valid_seen <= 1'b0;
    end else begin
      r_done  <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner      <= w_win;
            r_grant      <= NUM_REQ'(1) << w_win;
            r_data       <= req_data[int'(w_win)*DATA_W +: DATA_W];
            r_start      <= 1'b1;
            r_cnt        <= '0;
            r_valid_seen <= 1'b0;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (m_busy) r_state <= S_XFER;
          end
        end
        S_XFER: begin
          r_valid_seen <= r_valid_seen | m_valid;
          // A finishing transfer wins over a timeout landing on the same edge.
          if (!m_busy) begin
            if (r_valid_seen || m_valid) r_done <= r_grant;
            else                         r_err  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_ptr   <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign done    = r_done;
  assign err     = r_err;
  assign m_data  = r_data;
  assign m_start = r_start;

endmodule
